// File: rtl/adc_cic_decim_if.sv
// Sample handshake between the CIC decimator (master) and the readout/FIFO stage (slave).
interface adc_cic_decim_if #(
  parameter int OW = 20
);
  logic [OW-1:0] sample_data;
  logic          sample_valid;
  logic          sample_ready;

  modport master (output sample_data, output sample_valid, input sample_ready);
  modport slave  (input sample_data, input sample_valid, output sample_ready);
endinterface

// File: rtl/adc_cic_decim.sv
// Third-order CIC decimator for the 1-bit sigma-delta bitstream, with a valid/ready sample output.
// Optional macro ADC_CIC_SETTLE_EN: suppress the first 3 transient samples after reset or enable.
module adc_cic_decim #(
  parameter int LOG2_DECIM = 6,
  parameter int OW         = 3*LOG2_DECIM+2
) (
  input  logic            clk_s_d_out,
  input  logic            rst_adc,
  input  logic            din_i,
  input  logic            en_i,
  input  logic            ovr_clr_i,
  output logic            overrun_o,
  adc_cic_decim_if.master smp_if
);

  localparam logic [LOG2_DECIM-1:0] CNT_LAST = '1;

  logic [LOG2_DECIM-1:0] cnt_q, cnt_d;
  logic [OW-1:0] i1_q, i1_d, i2_q, i2_d, i3_q, i3_d;
  logic [OW-1:0] d1_q, d1_d, d2_q, d2_d, d3_q, d3_d;
  logic [OW-1:0] data_q, data_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;

  logic [OW-1:0] x, c1, c2, c3;
  logic          strobe, emit;

  // din=1 -> +1, din=0 -> -1 (all ones)
  assign x      = {{(OW-1){~din_i}}, 1'b1};
  assign c1     = i3_q - d1_q;
  assign c2     = c1 - d2_q;
  assign c3     = c2 - d3_q;
  assign strobe = en_i && (cnt_q == CNT_LAST);

`ifdef ADC_CIC_SETTLE_EN
  logic [1:0] settle_q, settle_d;

  assign emit = strobe && (settle_q == 2'd3);

  always_comb begin
    settle_d = settle_q;
    if (!en_i) begin
      settle_d = 2'd0;
    end else if (strobe && (settle_q != 2'd3)) begin
      settle_d = settle_q + 2'd1;
    end
  end

  always_ff @(posedge clk_s_d_out or posedge rst_adc) begin
    if (rst_adc) begin
      settle_q <= 2'd0;
    end else begin
      settle_q <= settle_d;
    end
  end
`else
  assign emit = strobe;
`endif

  always_comb begin
    cnt_d   = cnt_q;
    i1_d    = i1_q;
    i2_d    = i2_q;
    i3_d    = i3_q;
    d1_d    = d1_q;
    d2_d    = d2_q;
    d3_d    = d3_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovr_d   = ovr_q;

    if (ovr_clr_i) begin
      ovr_d = 1'b0;
    end

    if (!en_i) begin
      cnt_d   = '0;
      i1_d    = '0;
      i2_d    = '0;
      i3_d    = '0;
      d1_d    = '0;
      d2_d    = '0;
      d3_d    = '0;
      valid_d = 1'b0;
    end else begin
      cnt_d = cnt_q + LOG2_DECIM'(1);
      i1_d  = i1_q + x;
      i2_d  = i2_q + i1_q;
      i3_d  = i3_q + i2_q;
      if (strobe) begin
        d1_d = i3_q;
        d2_d = c1;
        d3_d = c2;
      end
      // A new sample replaces an unconsumed one; ready on the same edge counts as accepted.
      if (emit) begin
        data_d  = c3;
        valid_d = 1'b1;
        if (valid_q && !smp_if.sample_ready) begin
          ovr_d = 1'b1;
        end
      end else if (valid_q && smp_if.sample_ready) begin
        valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_s_d_out or posedge rst_adc) begin
    if (rst_adc) begin
      cnt_q   <= '0;
      i1_q    <= '0;
      i2_q    <= '0;
      i3_q    <= '0;
      d1_q    <= '0;
      d2_q    <= '0;
      d3_q    <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
      i3_q    <= i3_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      d3_q    <= d3_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign smp_if.sample_data  = data_q;
  assign smp_if.sample_valid = valid_q;
  assign overrun_o           = ovr_q;

endmodule

// File: tb/tb_adc_cic_decim.sv
// Bench for adc_cic_decim: steady-state vectors, handshake/reset corner cases, random stimulus vs closed-form CIC model.
module tb_adc_cic_decim;
  localparam int LOG2_DECIM = 6;
  localparam int DECIM      = 1 << LOG2_DECIM;
  localparam int OW         = 3*LOG2_DECIM+2;
`ifdef ADC_CIC_SETTLE_EN
  localparam int SKIP = 3;
`else
  localparam int SKIP = 0;
`endif

  logic clk_s_d_out = 1'b0;
  logic rst_adc, din_i, en_i, ovr_clr_i, overrun_o;

  adc_cic_decim_if #(.OW(OW)) smp_if ();

  adc_cic_decim #(.LOG2_DECIM(LOG2_DECIM)) dut (
    .clk_s_d_out (clk_s_d_out),
    .rst_adc     (rst_adc),
    .din_i       (din_i),
    .en_i        (en_i),
    .ovr_clr_i   (ovr_clr_i),
    .overrun_o   (overrun_o),
    .smp_if      (smp_if)
  );

  always #5 clk_s_d_out = ~clk_s_d_out;

  int checks = 0;
  int errors = 0;

  // Reference model: input history since enable, sample number, expected outputs.
  int            xs[$];
  int            ecnt;
  logic [OW-1:0] m_data;
  bit            m_valid, m_ovr;

  typedef struct {
    int            pat;
    logic [OW-1:0] exp_data;
    bit            exp_ovr;
  } vec_t;
  vec_t vecs[3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Third integrator after k edges in closed form: sum of x_j * (k-j)(k-j-1)/2.
  function automatic longint i3_at(input int k);
    longint s = 0;
    for (int j = 1; j <= k; j++) begin
      s += longint'(xs[j-1]) * (longint'(k-j) * longint'(k-j-1) / 2);
    end
    return s;
  endfunction

  task automatic model_reset();
    xs.delete();
    ecnt    = 0;
    m_data  = '0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic compare_outputs();
    check("sample_data", 32'(smp_if.sample_data), 32'(m_data));
    check("sample_valid", 32'(smp_if.sample_valid), 32'(m_valid));
    check("overrun", 32'(overrun_o), 32'(m_ovr));
  endtask

  task automatic tick();
    bit     d, e, r, c, v_pre, emit;
    longint val;
    int     n;
    d     = din_i;
    e     = en_i;
    r     = smp_if.sample_ready;
    c     = ovr_clr_i;
    v_pre = m_valid;
    emit  = 1'b0;
    val   = 0;
    @(posedge clk_s_d_out);
    if (!e) begin
      xs.delete();
      ecnt    = 0;
      m_valid = 1'b0;
      if (c) m_ovr = 1'b0;
    end else begin
      xs.push_back(d ? 1 : -1);
      ecnt++;
      if (ecnt % DECIM == 0) begin
        n    = ecnt;
        // Three comb stages = third finite difference over one decimation period.
        val  = i3_at(n-1) - 3*i3_at(n-1-DECIM) + 3*i3_at(n-1-2*DECIM) - i3_at(n-1-3*DECIM);
        emit = (ecnt / DECIM) > SKIP;
      end
      if (c) m_ovr = 1'b0;
      if (emit && v_pre && !r) m_ovr = 1'b1;
      if (emit) begin
        m_data  = val[OW-1:0];
        m_valid = 1'b1;
      end else if (v_pre && r) begin
        m_valid = 1'b0;
      end
    end
    #1;
    compare_outputs();
  endtask

  initial begin
    int lat;

    vecs[0] = '{pat: 1, exp_data: 20'h40000, exp_ovr: 1'b0};
    vecs[1] = '{pat: 0, exp_data: 20'hC0000, exp_ovr: 1'b0};
    vecs[2] = '{pat: 2, exp_data: 20'h00000, exp_ovr: 1'b0};

    rst_adc   = 1'b1;
    en_i      = 1'b0;
    din_i     = 1'b0;
    ovr_clr_i = 1'b0;
    smp_if.sample_ready = 1'b0;
    model_reset();
    #12;
    compare_outputs();
    @(negedge clk_s_d_out);
    rst_adc = 1'b0;

    // Steady-state vectors: fresh conversion, ready=1, six decimation periods.
    for (int v = 0; v < 3; v++) begin
      en_i      = 1'b0;
      ovr_clr_i = 1'b1;
      tick();
      ovr_clr_i = 1'b0;
      en_i      = 1'b1;
      smp_if.sample_ready = 1'b1;
      for (int k = 0; k < 6*DECIM; k++) begin
        din_i = (vecs[v].pat == 2) ? k[0] : vecs[v].pat[0];
        tick();
      end
      check($sformatf("steady_data_pat%0d", vecs[v].pat), 32'(smp_if.sample_data), 32'(vecs[v].exp_data));
      check($sformatf("steady_ovr_pat%0d", vecs[v].pat), 32'(overrun_o), 32'(vecs[v].exp_ovr));
    end

    // Consumer stalls across two emitted samples, then overrun is cleared.
    en_i = 1'b0;
    tick();
    en_i = 1'b1;
    smp_if.sample_ready = 1'b0;
    for (int k = 0; k < DECIM*(SKIP+2); k++) begin
      din_i = 1'($urandom_range(0, 1));
      tick();
    end
    check("stall_valid", 32'(smp_if.sample_valid), 32'd1);
    check("stall_overrun", 32'(overrun_o), 32'd1);
    ovr_clr_i = 1'b1;
    tick();
    ovr_clr_i = 1'b0;
    check("ovr_clr", 32'(overrun_o), 32'd0);
    smp_if.sample_ready = 1'b1;
    tick();
    check("accept_clears_valid", 32'(smp_if.sample_valid), 32'd0);

    // Reset mid-decimation (count 30) with a pending sample and overrun set.
    en_i = 1'b0;
    tick();
    en_i = 1'b1;
    smp_if.sample_ready = 1'b0;
    for (int k = 0; k < DECIM*(SKIP+2) + 30; k++) begin
      din_i = 1'($urandom_range(0, 1));
      tick();
    end
    check("pre_reset_overrun", 32'(overrun_o), 32'd1);
    rst_adc = 1'b1;
    model_reset();
    #1;
    check("rst_data", 32'(smp_if.sample_data), 32'd0);
    check("rst_valid", 32'(smp_if.sample_valid), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);
    repeat (3) @(posedge clk_s_d_out);
    @(negedge clk_s_d_out);
    rst_adc = 1'b0;
    smp_if.sample_ready = 1'b1;
    din_i = 1'b1;
    lat = -1;
    for (int k = 1; k <= DECIM*(SKIP+2); k++) begin
      tick();
      if (lat < 0 && smp_if.sample_valid) lat = k;
    end
    check("first_valid_edge", 32'(lat), 32'(DECIM*(SKIP+1)));

    // Random stimulus against the model.
    for (int k = 0; k < 3000; k++) begin
      din_i     = 1'($urandom_range(0, 1));
      smp_if.sample_ready = ($urandom_range(0, 3) != 0);
      ovr_clr_i = ($urandom_range(0, 99) == 0);
      en_i      = ($urandom_range(0, 699) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
